// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: reduces a stream of floating-point elements, one per
// beat, to a single scalar sum per vector.
//
// One pipelined fp_adder (latency L = FP_ADDER_LATENCY) is time-shared
// between L partial-sum slots. Consecutive elements rotate through the slots,
// so back-to-back input never waits on the adder loop. After the last element
// the slots are folded sequentially into one result.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   in_data    FP element (WIDTH bits)
//   in_valid   element present this cycle
//   in_last    final element of the vector (only meaningful with in_valid)
//   in_ready   high while accumulating
//   out_data   reduced sum, registered, held until the next result
//   out_valid  one-cycle pulse in the cycle out_data takes a new result
//   out_count  element count of the vector, registered with out_data
//              (present only when FP_STREAM_ACC_COUNT_EN is defined)
//
// Handshake: an element is consumed at a rising edge iff in_valid and
// in_ready are both high in that cycle; in_valid while in_ready is low is
// ignored, never buffered. There is no back-pressure on the output.
//
// Debug: the FSM state is held in the enum signal 'state' (S_ACCUM, S_WAIT,
// S_DRAIN, S_DONE) for checkers to bind to.
//
// Compile-time option: FP_STREAM_ACC_COUNT_EN adds the out_count port.

// Fixed-length shift register with synchronous clear.
module register_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DELAY-1];
endmodule

// IEEE-754 adder, round to nearest even, subnormals flushed to zero.
// The sum is formed combinationally and retimed through LATENCY stages;
// 'ready' marks an issue, 'valid' marks the matching result.
module fp_adder #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ready,
  output logic [WIDTH-1:0] o,
  output logic             valid
);
  localparam int EW   = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
  localparam int MW   = WIDTH - 1 - EW;
  localparam int FW   = MW + 4;            // hidden + fraction + guard/round/sticky
  localparam int EMAX = (1 << EW) - 1;

  logic [WIDTH-1:0] x, y, sum;
  logic             sx, sy, stk, round_up;
  int               ex, ey, e_res, sh, p;
  logic [FW-1:0]    mx, my, my_sh, nm;
  logic [FW:0]      acc;
  logic [MW:0]      fr;

  always_comb begin
    // x is the operand of larger magnitude, so the difference is never negative
    if (a[WIDTH-2:0] >= b[WIDTH-2:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sx = x[WIDTH-1];
    sy = y[WIDTH-1];
    ex = int'(x[WIDTH-2:MW]);
    ey = int'(y[WIDTH-2:MW]);
    mx = (ex == 0) ? '0 : {1'b1, x[MW-1:0], 3'b000};
    my = (ey == 0) ? '0 : {1'b1, y[MW-1:0], 3'b000};

    sh    = (ex - ey > FW) ? FW : ex - ey;
    my_sh = my >> sh;
    stk   = 1'b0;
    for (int i = 0; i < FW; i++) if (i < sh && my[i]) stk = 1'b1;
    my_sh[0] = my_sh[0] | stk;

    if (sx == sy) acc = {1'b0, mx} + {1'b0, my_sh};
    else          acc = {1'b0, mx} - {1'b0, my_sh};

    // Normalise so the hidden bit lands in nm[FW-1]; nm[FW-1]=0 means zero.
    p = 0;
    if (acc[FW]) begin
      nm    = acc[FW:1];
      nm[0] = nm[0] | acc[0];
      e_res = ex + 1;
    end else begin
      for (int i = 0; i < FW; i++) if (acc[i]) p = i;
      nm    = acc[FW-1:0] << (FW - 1 - p);
      e_res = ex - (FW - 1 - p);
    end

    // A fraction carry-out wraps to all zeros, which is exactly 1.0 * 2^(e+1).
    round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
    fr       = {1'b0, nm[FW-2:3]} + {{MW{1'b0}}, round_up};
    if (fr[MW]) e_res = e_res + 1;

    if (ex == EMAX) begin
      if (ey == EMAX && sx != sy) sum = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      else                        sum = x;
    end else if (!nm[FW-1]) begin
      sum = {sx & sy, {(WIDTH-1){1'b0}}};   // exact cancellation gives +0
    end else if (e_res <= 0) begin
      sum = {sx, {(WIDTH-1){1'b0}}};
    end else if (e_res >= EMAX) begin
      sum = {sx, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      sum = {sx, EW'(e_res), fr[MW-1:0]};
    end
  end

  logic [WIDTH:0] pipe_q;

  register_delay #(.WIDTH(WIDTH + 1), .DELAY(LATENCY)) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({ready, sum}),
    .q   (pipe_q)
  );

  assign valid = pipe_q[WIDTH];
  assign o     = pipe_q[WIDTH-1:0];
endmodule

module fp_stream_accumulator #(
  parameter int WIDTH            = 32,
  parameter int FP_ADDER_LATENCY = 11,
  parameter int MAX_LEN          = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
`ifdef FP_STREAM_ACC_COUNT_EN
  ,
  output logic [$clog2(MAX_LEN+1)-1:0] out_count
`endif
);
  localparam int L  = FP_ADDER_LATENCY;
  localparam int SW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(L + 1);
  localparam logic [CW-1:0] L_CW      = CW'(L);
  localparam logic [CW-1:0] MAX_CW    = CW'(MAX_LEN);
  localparam logic [SW-1:0] LAST_SLOT = SW'(L - 1);
  localparam logic [TW-1:0] L_TW      = TW'(L);

  typedef enum logic [1:0] {S_ACCUM, S_WAIT, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]    slot, fold_k, add_tag;
  logic [CW-1:0]    count, u_last;
  logic [L-1:0]     used;
  logic [WIDTH-1:0] psum [L];
  logic [WIDTH-1:0] total, add_a, add_b, add_o, psum0_now;
  logic [TW-1:0]    tmr;
  logic             add_ready, add_valid, accept, fwd;

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;

  // A result landing in the slot being issued this cycle bypasses psum;
  // this is exactly the back-to-back case, L accepts after the slot's last use.
  assign fwd = add_valid && (add_tag == slot);

  // Index of the last used slot: min(count, L) - 1.
  assign u_last = (count >= L_CW) ? L_CW - 1'b1 : count - 1'b1;

  // Slot 0 as it will read after this cycle's write-back.
  assign psum0_now = (add_valid && add_tag == '0) ? add_o : psum[0];

  always_comb begin
    add_ready = 1'b0;
    add_a     = in_data;
    add_b     = '0;
    case (state)
      S_ACCUM: begin
        if (accept) begin
          add_ready = 1'b1;
          if (used[slot]) add_b = fwd ? add_o : psum[slot];
        end
      end
      S_DRAIN: begin
        // one fold in flight at a time: issue only on the first drain cycle
        // and on the cycle after each result returns
        if (tmr == '0) begin
          add_ready = 1'b1;
          add_a     = total;
          add_b     = psum[fold_k];
        end
      end
      default: ;
    endcase
  end

  fp_adder #(.WIDTH(WIDTH), .LATENCY(L)) u_adder (
    .clk   (clk),
    .rst   (rst),
    .a     (add_a),
    .b     (add_b),
    .ready (add_ready),
    .o     (add_o),
    .valid (add_valid)
  );

  register_delay #(.WIDTH(SW), .DELAY(L)) u_tag (
    .clk (clk),
    .rst (rst),
    .d   (slot),
    .q   (add_tag)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACCUM: if (accept && in_last) state_nxt = S_WAIT;
      S_WAIT:  if (tmr == L_TW) state_nxt = (u_last == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (add_valid && CW'(fold_k) == u_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_ACCUM;
      default: state_nxt = S_ACCUM;
    endcase
  end

  // Partial sums carry no reset: the used bits decide whether a slot is live.
  always_ff @(posedge clk) begin
    if (add_valid && (state == S_ACCUM || state == S_WAIT)) psum[add_tag] <= add_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ACCUM;
      slot     <= '0;
      count    <= '0;
      used     <= '0;
      tmr      <= '0;
      fold_k   <= '0;
      total    <= '0;
      out_data <= '0;
`ifdef FP_STREAM_ACC_COUNT_EN
      out_count <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_ACCUM: begin
          if (accept) begin
            used[slot] <= 1'b1;
            slot       <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            if (count != MAX_CW) count <= count + 1'b1;
            // the cycle after the last accept is cycle 1 of the wait window
            tmr <= TW'(1);
          end
        end
        S_WAIT: begin
          if (tmr == L_TW) begin
            tmr    <= '0;
            fold_k <= SW'(1);
            total  <= psum0_now;
            if (u_last == '0) begin
              out_data <= psum0_now;
`ifdef FP_STREAM_ACC_COUNT_EN
              out_count <= count;
`endif
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (add_valid) begin
            tmr    <= '0;
            total  <= add_o;
            fold_k <= fold_k + 1'b1;
            if (CW'(fold_k) == u_last) begin
              out_data <= add_o;
`ifdef FP_STREAM_ACC_COUNT_EN
              out_count <= count;
`endif
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DONE: begin
          slot  <= '0;
          count <= '0;
          used  <= '0;
          tmr   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator (WIDTH=32, L=11, MAX_LEN=4096).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Cycle numbers are the count of rising edges so far; a vector's last element
// accepted in cycle T produces its out_valid pulse in cycle T + latency.
module tb_fp_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
`ifdef FP_STREAM_ACC_COUNT_EN
  logic [12:0] out_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_cnt_q[$];

  fp_stream_accumulator #(
    .WIDTH(32),
    .FP_ADDER_LATENCY(11),
    .MAX_LEN(4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
`ifdef FP_STREAM_ACC_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Small positive integer as IEEE single.
  function automatic logic [31:0] fp_of_int(input int n);
    int p;
    p = 0;
    for (int i = 0; i < 31; i++) if (((n >> i) & 1) != 0) p = i;
    return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h007f_ffff)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("result_data", out_data, exp_q.pop_front());
        check("result_cycle", cyc, exp_cyc_q.pop_front());
`ifdef FP_STREAM_ACC_COUNT_EN
        check("result_count", out_count, exp_cnt_q.pop_front());
`else
        void'(exp_cnt_q.pop_front());
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [31:0] d, input logic last);
    int guard;
    guard    = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_result(input logic [31:0] d, input int lat, input int n);
    exp_q.push_back(d);
    exp_cyc_q.push_back(acc_cyc + lat);
    exp_cnt_q.push_back(n);
  endtask

  task automatic wait_results(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
      exp_cnt_q.delete();
    end
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_last;
    int bad;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 32'h0);

    // 1.0 .. 20.0 back-to-back: 11 slots used, 210.0 at T+132
    for (int i = 1; i <= 20; i++) send(fp_of_int(i), (i == 20));
    t_last = acc_cyc;
    expect_result(32'h4352_0000, 132, 20);
    bad = 0;
    while (cyc <= t_last + 132) begin
      if (in_ready) bad++;
      @(negedge clk);
    end
    check("in_ready_low_window", bad, 0);
    check("in_ready_after_done", in_ready, 1);
    wait_results(50);

    // single element 3.5
    send(32'h4060_0000, 1'b1);
    expect_result(32'h4060_0000, 12, 1);
    wait_results(50);

    // single element -0.0 is summed with +0.0
    send(32'h8000_0000, 1'b1);
    expect_result(32'h0000_0000, 12, 1);
    wait_results(50);

    // 1.0, 2.0, 4.0 with two idle cycles between elements
    send(32'h3f80_0000, 1'b0);
    idle(2);
    send(32'h4000_0000, 1'b0);
    idle(2);
    send(32'h4080_0000, 1'b1);
    expect_result(32'h40e0_0000, 36, 3);
    wait_results(80);

    // junk held on in_valid while not ready must be ignored
    send(32'h3f80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    expect_result(32'h4040_0000, 24, 2);
    in_data  = 32'h7fc0_0000;
    in_last  = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!out_valid) check("junk_phase_done_timeout", 0, 1);
    send(32'h40a0_0000, 1'b0);
    send(32'h40a0_0000, 1'b1);
    expect_result(32'h4120_0000, 24, 2);
    wait_results(80);

    // reset in the middle of the drain phase
    send(32'h3f80_0000, 1'b0);
    send(32'h3f80_0000, 1'b0);
    send(32'h3f80_0000, 1'b1);
    t_last = acc_cyc;
    while (cyc < t_last + 16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    idle(40);
    send(32'h4000_0000, 1'b1);
    expect_result(32'h4000_0000, 12, 1);
    wait_results(50);

    // back-to-back vectors of 11 and 12 ones
    for (int i = 1; i <= 11; i++) send(32'h3f80_0000, (i == 11));
    expect_result(32'h4130_0000, 132, 11);
    for (int i = 1; i <= 12; i++) send(32'h3f80_0000, (i == 12));
    expect_result(32'h4140_0000, 132, 12);
    wait_results(200);

    check("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
